// File: rtl/debounce3.sv
// debounce3 - three-channel switch conditioner feeding the 3-input AND stage.
//
// Each raw switch level is synchronised with two flops, then debounced by a
// small FSM and a CNT_W-bit down-counter. A new level is accepted only if it
// holds for 2^CNT_W+1 consecutive synchronised samples. Every channel runs
// independently; only clk and reset_n are shared.
//
// Ports:
//   clk      - system clock, all logic on the rising edge
//   reset_n  - synchronous active-low reset
//   sw_in    - raw asynchronous switch levels (bit0->a, bit1->b, bit2->c)
//   db_out   - debounced registered levels for the AND stage
//   db_rise  - one-cycle pulse per channel when db_out[i] goes 0->1
//   db_fall  - one-cycle pulse per channel when db_out[i] goes 1->0
module debounce3 #(
  parameter int unsigned CNT_W = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] sw_in,
  output logic [2:0] db_out,
  output logic [2:0] db_rise,
  output logic [2:0] db_fall
);

  localparam logic [1:0] ZERO  = 2'd0;
  localparam logic [1:0] WAIT1 = 2'd1;
  localparam logic [1:0] ONE   = 2'd2;
  localparam logic [1:0] WAIT0 = 2'd3;

  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [1:0]       state [3];
  logic [CNT_W-1:0] cnt   [3];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1      <= '0;
      s2      <= '0;
      db_out  <= '0;
      db_rise <= '0;
      db_fall <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        state[i] <= ZERO;
        cnt[i]   <= '0;
      end
    end else begin
      s1      <= sw_in;
      s2      <= s1;
      // Pulses default low; a commit below raises them for exactly one cycle.
      db_rise <= '0;
      db_fall <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        case (state[i])
          ZERO: begin
            if (s2[i]) begin
              state[i] <= WAIT1;
              cnt[i]   <= '1;
            end
          end
          WAIT1: begin
            if (!s2[i]) begin
              state[i] <= ZERO;
            end else if (cnt[i] != '0) begin
              cnt[i] <= cnt[i] - 1'b1;
            end else begin
              state[i]   <= ONE;
              db_out[i]  <= 1'b1;
              db_rise[i] <= 1'b1;
            end
          end
          ONE: begin
            if (!s2[i]) begin
              state[i] <= WAIT0;
              cnt[i]   <= '1;
            end
          end
          WAIT0: begin
            if (s2[i]) begin
              state[i] <= ONE;
            end else if (cnt[i] != '0) begin
              cnt[i] <= cnt[i] - 1'b1;
            end else begin
              state[i]   <= ZERO;
              db_out[i]  <= 1'b0;
              db_fall[i] <= 1'b1;
            end
          end
          default: begin
            state[i] <= ZERO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debounce3.sv
// tb_debounce3 - directed self-checking bench for debounce3 with CNT_W=4.
//
// Inputs change #1 after a rising edge and outputs are sampled at the same
// point, so "edge k" is the first edge after an input change. With CNT_W=4
// a committed change appears on the 18th edge counted from edge k.
module tb_debounce3;

  logic       clk;
  logic       reset_n;
  logic [2:0] sw_in;
  logic [2:0] db_out;
  logic [2:0] db_rise;
  logic [2:0] db_fall;

  int n_checks;
  int n_fail;

  debounce3 #(.CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw_in   (sw_in),
    .db_out  (db_out),
    .db_rise (db_rise),
    .db_fall (db_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges; after each, db_out must equal lvl and no pulse may occur.
  task automatic run_expect(input string tag, input int n, input logic [2:0] lvl);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_out"},  {29'd0, db_out},  {29'd0, lvl});
      check({tag, "_rise"}, {29'd0, db_rise}, 32'd0);
      check({tag, "_fall"}, {29'd0, db_fall}, 32'd0);
    end
  endtask

  // Check all three outputs at the current sample point.
  task automatic expect_all(input string tag, input logic [2:0] lvl,
                            input logic [2:0] rise, input logic [2:0] fall);
    check({tag, "_out"},  {29'd0, db_out},  {29'd0, lvl});
    check({tag, "_rise"}, {29'd0, db_rise}, {29'd0, rise});
    check({tag, "_fall"}, {29'd0, db_fall}, {29'd0, fall});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    sw_in    = 3'b111;

    // Reset held for 3 edges with all switches high.
    run_expect("reset", 3, 3'b000);
    reset_n = 1'b1;
    tick();
    expect_all("post_release", 3'b000, 3'b000, 3'b000);
    sw_in = 3'b000;
    run_expect("settle", 20, 3'b000);

    // Clean rise on channel 0: commit on edge k+18.
    sw_in = 3'b001;
    run_expect("rise0_wait", 18, 3'b000);
    tick();
    expect_all("rise0_commit", 3'b001, 3'b001, 3'b000);
    tick();
    expect_all("rise0_after", 3'b001, 3'b000, 3'b000);

    // Bounce on channel 1: 1,0,1,0 for 3 cycles each, then hold 1.
    sw_in = 3'b011; run_expect("bounce_h1", 3, 3'b001);
    sw_in = 3'b001; run_expect("bounce_l1", 3, 3'b001);
    sw_in = 3'b011; run_expect("bounce_h2", 3, 3'b001);
    sw_in = 3'b001; run_expect("bounce_l2", 3, 3'b001);
    sw_in = 3'b011; run_expect("bounce_hold", 18, 3'b001);
    tick();
    expect_all("bounce_commit", 3'b011, 3'b010, 3'b000);
    tick();
    expect_all("bounce_after", 3'b011, 3'b000, 3'b000);

    // Bring channel 2 to ONE.
    sw_in = 3'b111;
    run_expect("rise2_wait", 18, 3'b011);
    tick();
    expect_all("rise2_commit", 3'b111, 3'b100, 3'b000);

    // Channel 2 falls; a one-cycle return to 1 lands on the counter==0
    // sample (edge k+18), so the fall aborts and restarts from edge k+17.
    sw_in = 3'b011; run_expect("glitch_low", 16, 3'b111);
    sw_in = 3'b111; run_expect("glitch_high", 1, 3'b111);
    sw_in = 3'b011; run_expect("fall2_wait", 18, 3'b111);
    tick();
    expect_all("fall2_commit", 3'b011, 3'b000, 3'b100);
    tick();
    expect_all("fall2_after", 3'b011, 3'b000, 3'b000);

    // Channels 0 and 1 fall together.
    sw_in = 3'b000;
    run_expect("fall01_wait", 18, 3'b011);
    tick();
    expect_all("fall01_commit", 3'b000, 3'b000, 3'b011);
    tick();

    // All three rise on the same edge; AND of db_out goes high there.
    sw_in = 3'b111;
    run_expect("conc_wait", 18, 3'b000);
    tick();
    expect_all("conc_commit", 3'b111, 3'b111, 3'b000);
    check("conc_and", {31'd0, &db_out}, 32'd1);
    tick();
    expect_all("conc_after", 3'b111, 3'b000, 3'b000);

    // Return everything to ZERO.
    sw_in = 3'b000;
    run_expect("clr_wait", 18, 3'b111);
    tick();
    expect_all("clr_commit", 3'b000, 3'b000, 3'b111);
    tick();

    // Channel 0 in WAIT1 with counter at 5 (after edge k+12), then reset.
    sw_in = 3'b001;
    run_expect("mid_wait", 13, 3'b000);
    reset_n = 1'b0;
    tick();
    expect_all("mid_reset", 3'b000, 3'b000, 3'b000);
    reset_n = 1'b1;
    run_expect("mid_restart", 18, 3'b000);
    tick();
    expect_all("mid_commit", 3'b001, 3'b001, 3'b000);
    tick();
    expect_all("mid_after", 3'b001, 3'b000, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce3.md
# debounce3

Three-channel input conditioner that sits directly upstream of the 3-input AND stage. It takes raw board switch or button levels and synchronises each one into the clock domain. It debounces each channel independently and drives the stable levels onto the AND stage's `a`, `b`, `c` inputs. It also produces one-cycle rise and fall pulses per channel for later counting or control logic.

## Interface
- `CNT_W`, default 20: debounce counter width. The stable window is 2^CNT_W cycles, about 10.5 ms at 100 MHz. The bench uses 4.
- `clk` input 1: single system clock. All logic is on the rising edge.
- `reset_n` input 1: reset, synchronous, active-low. Sampled on the `clk` rising edge only.
- `sw_in` input [2:0]: raw asynchronous switch levels. Bit 0 feeds `a`, bit 1 feeds `b`, bit 2 feeds `c`.
- `db_out` output [2:0]: debounced registered levels, wired to the AND stage inputs.
- `db_rise` output [2:0]: one-cycle pulse when `db_out[i]` goes 0->1.
- `db_fall` output [2:0]: one-cycle pulse when `db_out[i]` goes 1->0.

## Operation
- Per channel, a 2-flop synchroniser (`s1`, then `s2`) feeds an independent FSM and a CNT_W-bit down-counter. No logic is shared between channels except `clk` and `reset_n`.
- FSM states and transitions:
  - ZERO, `db_out`=0:
    - `s2`=1 -> WAIT1, counter loaded with all-ones.
  - WAIT1, `db_out`=0:
    - `s2`=0 -> ZERO. Abort: no pulse, counter value don't-care.
    - `s2`=1 and counter!=0 -> decrement.
    - `s2`=1 and counter==0 -> ONE. Assert `db_rise[i]` for that one cycle.
  - ONE, `db_out`=1:
    - `s2`=0 -> WAIT0, counter loaded with all-ones.
  - WAIT0, `db_out`=1:
    - `s2`=1 -> ONE. Abort, no pulse.
    - `s2`=0 and counter!=0 -> decrement.
    - `s2`=0 and counter==0 -> ZERO. Assert `db_fall[i]` for that one cycle.
- Output registers:
  - `db_out[i]` is 1 exactly in ONE/WAIT0.
  - `db_out`, `db_rise` and `db_fall` are all registered, updated on the same edge as the state.
  - `db_rise[i]`/`db_fall[i]` are high for exactly one cycle and are never both high. They are never high outside a ZERO<->ONE commit.
- Counter arithmetic:
  - Unsigned, CNT_W bits.
  - Loads all-ones on entry to WAIT1 or WAIT0.
  - Never decrements below 0, so it has no wrap-around.
  - Holds in ZERO/ONE.
- A glitch of any length shorter than the window produces no output change and no pulse. The level must hold through the counter==0 cycle.
- Simultaneous events: channels may commit on the same edge. Each channel pulses independently, so e.g. `db_rise`=3'b101 is legal.

## Timing
- Reset while `reset_n`=0 at a rising edge:
  - `s1`=`s2`=0, state ZERO, counter 0.
  - `db_out`=3'b000, `db_rise`=3'b000, `db_fall`=3'b000.
  - Takes effect on that edge. It overrides every transition, including mid-WAIT1/WAIT0 and an in-flight pulse.
- After `reset_n` rises with `sw_in[i]`=1, the channel debounces normally. `db_out[i]` goes to 1 after the standard latency, with a `db_rise` pulse.
- Latency is measured with the raw level stable from edge k, i.e. first sampled by `s1` at edge k:
  - `s2` valid after k+1.
  - WAIT1 entered at k+2.
  - `db_out` and pulse at edge k+2+2^CNT_W.
  - For CNT_W=4 that is 18 edges after k. Falling is symmetric.
- Minimum stable input to propagate is 2^CNT_W+1 consecutive `s2` samples.
- Throughput: one committed transition per channel per 2^CNT_W+1 cycles at most.
- No combinational path from `sw_in` to any output.

## Test plan
- Reset values: hold `reset_n`=0 for 3 edges with `sw_in`=3'b111 -> all outputs 3'b000 throughout, and 3'b000 on the first edge after release.
- Clean rise, CNT_W=4:
  - Stimulus: `sw_in[0]` 0->1 before edge k, then held.
  - Required: `db_out[0]`=1 and `db_rise`=3'b001 after edge k+18, `db_rise` back to 0 one edge later.
  - Required: `db_out[0]` stays 0 through edge k+17.
- Bounce rejection:
  - Stimulus: `sw_in[1]` toggles 1,0,1,0 every 3 cycles, then holds 1.
  - Required: no `db_rise` and `db_out[1]`=0 until 18 edges after the last 0->1 sample. Then exactly one `db_rise`=3'b010.
- Clean fall plus edge case:
  - Stimulus: from ONE, `sw_in[2]` 1->0 held.
  - Required: `db_fall`=3'b100 and `db_out[2]`=0 at k+18.
  - Edge case: a 1-cycle return to 1 landing on the counter==0 sample -> no fall, state back to ONE.
- Concurrent channels:
  - Stimulus: `sw_in` 3'b000->3'b111 on the same edge.
  - Required: `db_rise`=3'b111 on a single edge, `db_out`=3'b111. Downstream AND output becomes 1 the same cycle.
- Reset mid-operation:
  - Stimulus: `reset_n` low for 1 edge while channel 0 is in WAIT1 with counter at 5.
  - Required: outputs 3'b000 and no pulse. With `sw_in[0]` still 1, `db_rise[0]` appears 18 edges after the release edge.
